// File: rtl/datapath_pkg.sv
// datapath_pkg: shared opcodes, control-word field layout and flag indices for datapath_pipe
package datapath_pkg;
  localparam logic [3:0] FS_PASSA  = 4'b0000;
  localparam logic [3:0] FS_INC    = 4'b0001;
  localparam logic [3:0] FS_ADD    = 4'b0010;
  localparam logic [3:0] FS_ADDC   = 4'b0011;
  localparam logic [3:0] FS_SUBB   = 4'b0100;
  localparam logic [3:0] FS_SUB    = 4'b0101;
  localparam logic [3:0] FS_DEC    = 4'b0110;
  localparam logic [3:0] FS_PASSA2 = 4'b0111;
  localparam logic [3:0] FS_AND    = 4'b1000;
  localparam logic [3:0] FS_OR     = 4'b1001;
  localparam logic [3:0] FS_XOR    = 4'b1010;
  localparam logic [3:0] FS_NOT    = 4'b1011;
  localparam logic [3:0] FS_PASSB  = 4'b1100;
  localparam logic [3:0] FS_SHR    = 4'b1101;
  localparam logic [3:0] FS_SHL    = 4'b1110;
  localparam logic [3:0] FS_PASSB2 = 4'b1111;
  localparam int CW_RW     = 0;
  localparam int CW_MD     = 1;
  localparam int CW_FS_LSB = 2;
  localparam int CW_MB     = 6;
  localparam int CW_BA_LSB = 7;
  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;
  function automatic int cw_aa_lsb(input int aw);
    return 7 + aw;
  endfunction
  function automatic int cw_da_lsb(input int aw);
    return 7 + 2 * aw;
  endfunction
  function automatic int cw_width(input int aw);
    return 3 * aw + 7;
  endfunction
endpackage

// File: rtl/dp_alu.sv
// dp_alu: combinational ALU/shifter; ports a, b, fs in; f result, c carry/shift-out, v signed overflow out
module dp_alu
  import datapath_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       fs,
  output logic [WIDTH-1:0] f,
  output logic             c,
  output logic             v
);
  logic [WIDTH-1:0] bop;
  logic             cin;
  logic [WIDTH:0]   sum;
  always_comb begin
    bop = '0;
    cin = 1'b0;
    case (fs)
      FS_INC:  cin = 1'b1;
      FS_ADD:  bop = b;
      FS_ADDC: begin bop = b; cin = 1'b1; end
      FS_SUBB: bop = ~b;
      FS_SUB:  begin bop = ~b; cin = 1'b1; end
      FS_DEC:  bop = '1;
      default: ;
    endcase
    sum = {1'b0, a} + {1'b0, bop} + {{WIDTH{1'b0}}, cin};
    f = a;
    c = 1'b0;
    v = 1'b0;
    case (fs)
      FS_INC, FS_ADD, FS_ADDC, FS_SUBB, FS_SUB, FS_DEC: begin
        f = sum[WIDTH-1:0];
        c = sum[WIDTH];
        // overflow: both addends share a sign that the result does not
        v = (a[WIDTH-1] == bop[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      FS_PASSA, FS_PASSA2: f = a;
      FS_AND:  f = a & b;
      FS_OR:   f = a | b;
      FS_XOR:  f = a ^ b;
      FS_NOT:  f = ~a;
      FS_PASSB, FS_PASSB2: f = b;
      FS_SHR:  begin f = {1'b0, b[WIDTH-1:1]}; c = b[0]; end
      FS_SHL:  begin f = {b[WIDTH-2:0], 1'b0}; c = b[WIDTH-1]; end
      default: f = a;
    endcase
  end
endmodule

// File: rtl/datapath_pipe.sv
// datapath_pipe: two-stage register-file datapath (operand capture, then ALU + write-back + V/C/N/Z flags).
// Ports: CLK, RESET_N (async active-low); CTRWRD/CTRWRD_VALID/CTRWRD_READY control handshake;
// Cin constant, Din memory data; Dout/Adrout registered operands; V/C/N/Z flags; WB_VALID/WB_ADDR/WB_DATA write-back.
// Macro DATAPATH_PIPE_FWD_EN: forward stage-2 result into operand read instead of stalling one cycle.
module datapath_pipe
  import datapath_pkg::*;
#(
  parameter  int WIDTH = 16,
  parameter  int NREG  = 8,
  localparam int AW    = $clog2(NREG),
  localparam int CW_W  = cw_width(AW)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [CW_W-1:0]  CTRWRD,
  input  logic             CTRWRD_VALID,
  output logic             CTRWRD_READY,
  input  logic [WIDTH-1:0] Cin,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Dout,
  output logic [WIDTH-1:0] Adrout,
  output logic             V,
  output logic             C,
  output logic             N,
  output logic             Z,
  output logic             WB_VALID,
  output logic [AW-1:0]    WB_ADDR,
  output logic [WIDTH-1:0] WB_DATA
);
  logic [AW-1:0]    da, aa, ba, e_da;
  logic [3:0]       fs, e_fs, flg;
  logic             mb, md, rw, e_valid, e_md, e_rw, hit_a, hit_b, accept, alu_c, alu_v;
  logic [WIDTH-1:0] rf [NREG];
  logic [WIDTH-1:0] e_din, f, op_a, rf_b, op_b;
  assign da = CTRWRD[cw_da_lsb(AW) +: AW];
  assign aa = CTRWRD[cw_aa_lsb(AW) +: AW];
  assign ba = CTRWRD[CW_BA_LSB +: AW];
  assign mb = CTRWRD[CW_MB];
  assign fs = CTRWRD[CW_FS_LSB +: 4];
  assign md = CTRWRD[CW_MD];
  assign rw = CTRWRD[CW_RW];
  dp_alu #(.WIDTH(WIDTH)) u_alu (.a(Adrout), .b(Dout), .fs(e_fs), .f(f), .c(alu_c), .v(alu_v));
  assign WB_VALID = e_valid & e_rw;
  assign WB_ADDR  = e_da;
  assign WB_DATA  = e_md ? e_din : f;
  assign {V, C, N, Z} = {flg[FLAG_V], flg[FLAG_C], flg[FLAG_N], flg[FLAG_Z]};
  // a read of the register stage 2 is about to write would see the old value
  assign hit_a = WB_VALID && (aa == e_da);
  assign hit_b = WB_VALID && !mb && (ba == e_da);
`ifdef DATAPATH_PIPE_FWD_EN
  assign CTRWRD_READY = 1'b1;
  assign op_a = hit_a ? WB_DATA : rf[aa];
  assign rf_b = hit_b ? WB_DATA : rf[ba];
`else
  // one bubble lets the write land so the held word reads the updated register
  assign CTRWRD_READY = !(hit_a || hit_b);
  assign op_a = rf[aa];
  assign rf_b = rf[ba];
`endif
  assign op_b   = mb ? Cin : rf_b;
  assign accept = CTRWRD_VALID & CTRWRD_READY;
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      rf      <= '{default: '0};
      e_valid <= 1'b0;
      e_da    <= '0;
      e_fs    <= '0;
      e_md    <= 1'b0;
      e_rw    <= 1'b0;
      e_din   <= '0;
      Adrout  <= '0;
      Dout    <= '0;
      flg     <= '0;
    end else begin
      e_valid <= accept;
      if (accept) begin
        e_da   <= da;
        e_fs   <= fs;
        e_md   <= md;
        e_rw   <= rw;
        e_din  <= Din;
        Adrout <= op_a;
        Dout   <= op_b;
      end
      if (WB_VALID) rf[e_da] <= WB_DATA;
      if (e_valid && !e_md) begin
        flg[FLAG_V] <= alu_v;
        flg[FLAG_C] <= alu_c;
        flg[FLAG_N] <= f[WIDTH-1];
        flg[FLAG_Z] <= (f == '0);
      end
    end
  end
endmodule

// File: doc/datapath_pipe.md
# datapath_pipe

Parametrised two-stage successor to the single-cycle register-file datapath. Accepts one control word per cycle under a valid/ready handshake and captures operands in stage 1. Executes the ALU/shifter and writes back in stage 2, registering the V/C/N/Z status flags. It sits between the microsequencer (control words, constant) and memory (Din in, Dout/Adrout out).

## Interface
- `WIDTH`, 16: data path width in bits (≥4).
- `NREG`, 8: register count, power of two; `AW = log2(NREG)`.
- `CW_W`, `3*AW+7`, derived: control word width (16 at defaults).
- `CLK` in 1: clock, rising edge.
- `RESET_N` in 1: reset, asynchronous, active-low.
- `CTRWRD` in CW_W: control word, MSB first: `DA[AW]`, `AA[AW]`, `BA[AW]`, `MB`, `FS[4]`, `MD`, `RW`.
- `CTRWRD_VALID` in 1: control word present.
- `CTRWRD_READY` out 1: control word accepted on this edge if VALID.
- `Cin` in WIDTH: constant operand, used when MB=1.
- `Din` in WIDTH: memory data, used for write-back when MD=1.
- `Dout` out WIDTH: stage-2 B operand (after MB mux), registered.
- `Adrout` out WIDTH: stage-2 A operand, registered.
- `V`, `C`, `N`, `Z` out 1 each: registered status flags.
- `WB_VALID` out 1, `WB_ADDR` out AW, `WB_DATA` out WIDTH: write-back occurring on the next edge.

## Operation
- Accept when `CTRWRD_VALID & CTRWRD_READY`. Stage 1 latches A=RF[AA], B=MB?Cin:RF[BA], Din, and DA/FS/MD/RW into the E register. It sets e_valid. With no accept, it loads a bubble (e_valid=0).
- Stage 2 computes F from FS:
  - 0000 A
  - 0001 A+1
  - 0010 A+B
  - 0011 A+B+1
  - 0100 A+~B
  - 0101 A+~B+1
  - 0110 A−1
  - 0111 A
  - 1000 A&B
  - 1001 A|B
  - 1010 A^B
  - 1011 ~A
  - 1100 B
  - 1101 B>>1
  - 1110 B<<1
  - 1111 B
- Result = MD ? e_Din : F. If `e_valid & e_RW`, RF[e_DA] ← result at the edge.
- Arithmetic is performed in WIDTH+1 bits. C is the carry out. V is signed overflow (operand signs equal, result sign differs). For logic ops and pass-through, C=V=0. For shifts, C is the bit shifted out and V=0.
- Flags update only when `e_valid & ~e_MD`: N=F[WIDTH-1], Z=(F==0). Otherwise they hold.
- `WB_VALID = e_valid & e_RW`; `WB_ADDR = e_DA`; `WB_DATA` = result.
- Hazard: an incoming word whose AA, or BA with MB=0, equals e_DA while WB_VALID=1 (handling: see Configuration).
- No hardwired register; same-cycle read and write of the same address is always resolved by forwarding or stall, never a stale value.

## Timing
- Latency: word accepted at edge k → Dout/Adrout valid after k. RF write, flags and WB_DATA committed at edge k+1.
- Throughput: one word per cycle without hazard.
- Reset (asynchronous, any time): RF, E register, e_valid, Dout, Adrout, V/C/N/Z, WB_* all 0. A pending write-back is discarded. `CTRWRD_READY` = 1 during and after reset.
- Reset released mid-stream: the first edge with RESET_N=1 may accept a word.
- `CTRWRD_READY` is combinational from CTRWRD and E-stage state. No combinational path to data outputs.
- Back-to-back writes to the same DA: the later word wins.

## Configuration
- `DATAPATH_PIPE_FWD_EN` defined: on a hazard, the stage-2 result is forwarded into the stage-1 operand mux. `CTRWRD_READY` is constant 1.
- Undefined: on a hazard, `CTRWRD_READY`=0 for exactly one cycle and a bubble is inserted. The word is accepted the next cycle and reads the updated RF. Results are identical to forwarding; only the timing differs.

## Structure
- Package `datapath_pkg`:
  - FS opcode localparams (`FS_ADD`, `FS_SUB`, `FS_SHR`, …).
  - Control-word field offset/width functions of AW.
  - Flag index constants.
- Sub-module `dp_alu`, combinational: A, B, FS in; F, C, V out. Instantiated once in stage 2. The RF and pipeline register live in `datapath_pipe`.

## Test plan
- Reset, then 8 words `DA=i, MD=1, RW=1` with Din=i → WB_DATA 0..7 on consecutive cycles; R7 reads 7.
- R3 ← R1+R2 (FS=0010), then R4 ← R3+R3 back-to-back:
  - WB_DATA 3 then 6.
  - With FWD_EN, READY stays 1.
  - Without FWD_EN, READY is low exactly one cycle and the result is still 6.
- Overflow: R5=16'h7FFF, R6=1, R5+R6 → 16'h8000, V=1, N=1, C=0, Z=0. Then R6−R6 (FS=0101) → 0, Z=1, C=1, V=0.
- Constant and shift:
  - Cin=16'h8001, MB=1, FS=1110 → WB_DATA 16'h0002, C=1, Dout=16'h8001.
  - FS=1101 with B=16'h0003 → 16'h0001, C=1.
- RESET_N pulsed low mid-cycle while WB_VALID=1 → all outputs 0 immediately; target register not written; RF reads 0 after release.
- MD=1 load with flags previously Z=1 → flags unchanged, WB_DATA=Din.
